// File: rtl/cordic_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_arbiter_pkg
// Description : Shared defaults and helper function for the CORDIC request
//               arbiter slice (data width default, tag width helper).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_req_arbiter_pkg;

    localparam int c_CHORD_DATA_W     = 32;
    localparam int c_DEF_N_REQ        = 4;
    localparam int c_DEF_MAX_INFLIGHT = 16;

    // Ceiling log2, floored at 1 so a tag or index field never collapses
    // to zero width.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : cordic_req_arbiter_pkg
`default_nettype wire

// File: rtl/cordic_req_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_arbiter_tag_fifo
// Description : Synchronous show-ahead FIFO holding the requester ID of each
//               in-flight op. Push and pop may occur in the same cycle, even
//               while full (the pop frees the slot the push consumes).
// Ports       : clk, rst_n          clock / async active-low reset
//               i_push, i_push_data write side
//               i_pop, o_pop_data   read side (o_pop_data valid when !o_empty)
//               o_empty, o_full     status
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_req_arbiter_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule : cordic_req_arbiter_tag_fifo
`default_nettype wire

// File: rtl/cordic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_req_arbiter
// Description : Shares one in-order CORDIC core among N_REQ requesters.
//               Round-robin grant, at most one operand issued per cycle,
//               requester ID tagged per op and the result routed back.
// Ports       : HCLK, HRESETn        clock / async active-low reset
//               en                   grant enable (in-flight ops still retire)
//               req_valid/req_data   requester operands
//               req_ready            one-hot combinational grant
//               core_in/_valid       registered operand to the core
//               core_out/_valid      result from the core
//               rsp_data/rsp_valid   registered result + one-hot owner pulse
//               inflight, idle       occupancy status
//               err_orphan           sticky: result with nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_req_arbiter
    import cordic_req_arbiter_pkg::*;
#(
    parameter int N_REQ        = c_DEF_N_REQ,
    parameter int DATA_W       = c_CHORD_DATA_W,
    parameter int MAX_INFLIGHT = c_DEF_MAX_INFLIGHT
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    input  logic                              en,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*DATA_W-1:0]           req_data,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [DATA_W-1:0]                 core_in,
    output logic                              core_in_valid,
    input  logic [DATA_W-1:0]                 core_out,
    input  logic                              core_out_valid,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              idle,
    output logic                              err_orphan
);

    localparam int               c_TAG_W = clog2_min1(N_REQ);
    localparam int               c_CNT_W = $clog2(MAX_INFLIGHT+1);
    localparam logic [N_REQ-1:0] c_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [c_TAG_W-1:0] r_ptr;
    logic [DATA_W-1:0]  r_core_in;
    logic               r_core_in_valid;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [c_CNT_W-1:0] r_inflight;
    logic               r_err_orphan;

    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_retire;
    logic               w_grant_en;
    logic               w_xfer;
    logic [c_TAG_W-1:0] w_gnt_idx;
    logic [c_TAG_W-1:0] w_scan;
    logic [DATA_W-1:0]  w_gnt_data;

    // A result only retires when an op is actually tracked; otherwise it is
    // an orphan and must not pop or pulse anyone.
    assign w_retire = core_out_valid & ~w_fifo_empty;

    // A retire in the same cycle frees a slot, so a full pipe can still
    // accept one op. The FIFO full flag mirrors the counter and only guards
    // against the two ever disagreeing.
    assign w_grant_en = en & (((r_inflight < c_CNT_W'(MAX_INFLIGHT)) & ~w_fifo_full)
                              | w_retire);

    // Round-robin scan starting just above the last granted requester.
    always_comb begin
        w_xfer    = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        if (w_grant_en) begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_scan = c_TAG_W'((int'(r_ptr) + k) % N_REQ);
                if (!w_xfer && req_valid[w_scan]) begin
                    w_xfer    = 1'b1;
                    w_gnt_idx = w_scan;
                end
            end
        end
    end

    assign req_ready  = w_xfer ? (c_ONE << w_gnt_idx) : '0;
    assign w_gnt_data = req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];

    cordic_req_arbiter_tag_fifo #(
        .WIDTH (c_TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .i_push      (w_xfer),
        .i_push_data (w_gnt_idx),
        .i_pop       (w_retire),
        .o_pop_data  (w_tag),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Issue side: pointer and operand register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ptr           <= c_TAG_W'(N_REQ-1);
            r_core_in       <= '0;
            r_core_in_valid <= 1'b0;
        end else begin
            r_core_in_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr     <= w_gnt_idx;
                r_core_in <= w_gnt_data;
            end
        end
    end

    // Response side: result register, owner pulse and orphan flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_data   <= '0;
            r_rsp_valid  <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_rsp_valid <= w_retire ? (c_ONE << w_tag) : '0;
            if (w_retire) begin
                r_rsp_data <= core_out;
            end
            if (core_out_valid && w_fifo_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Occupancy counter; a simultaneous issue and retire cancel out.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, w_retire})
                2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign core_in       = r_core_in;
    assign core_in_valid = r_core_in_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_valid     = r_rsp_valid;
    assign inflight      = r_inflight;
    assign err_orphan    = r_err_orphan;
    assign idle          = (r_inflight == '0) & ~r_core_in_valid;

endmodule : cordic_req_arbiter
`default_nettype wire

// File: tb/tb_cordic_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_req_arbiter
// Description : Directed self-checking bench for cordic_req_arbiter with a
//               fixed-latency core model (result = ~operand) and a manual
//               core mode for single-op, full, en-drop and orphan scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_req_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 16;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [W-1:0]   rd [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   core_in;
    logic           core_in_valid;
    logic [W-1:0]   core_out;
    logic           core_out_valid;
    logic [W-1:0]   rsp_data;
    logic [N-1:0]   rsp_valid;
    logic [4:0]     inflight;
    logic           idle;
    logic           err_orphan;

    // Core model controls
    logic           core_auto;
    logic           man_valid;
    logic [W-1:0]   man_data;
    logic [LAT-1:0] pv;
    logic [W-1:0]   pd [LAT];

    // Scoreboard and bookkeeping
    int             q_id [$];
    logic [W-1:0]   q_op [$];
    int             n_tot, n_pass, sb_err, n_rsp;
    logic           gnt_seen;
    int             gnt_idx;
    logic           pend;
    int             pend_idx;

    assign req_data = {rd[3], rd[2], rd[1], rd[0]};

    cordic_req_arbiter #(
        .N_REQ        (N),
        .DATA_W       (W),
        .MAX_INFLIGHT (16)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .en             (en),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .core_in        (core_in),
        .core_in_valid  (core_in_valid),
        .core_out       (core_out),
        .core_out_valid (core_out_valid),
        .rsp_data       (rsp_data),
        .rsp_valid      (rsp_valid),
        .inflight       (inflight),
        .idle           (idle),
        .err_orphan     (err_orphan)
    );

    always #5 HCLK = ~HCLK;

    // Fixed-latency core: returns the bitwise inverse of each operand.
    always @(negedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pv <= '0;
        end else begin
            pv    <= {pv[LAT-2:0], core_in_valid & core_auto};
            pd[0] <= ~core_in;
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end

    assign core_out_valid = core_auto ? pv[LAT-1] : man_valid;
    assign core_out       = core_auto ? pd[LAT-1] : man_data;

    // One clock of stimulus: scoreboard the previous response, drive inputs,
    // then record any grant made this cycle.
    task automatic cycle(input logic [N-1:0] v, input logic ret, input logic e);
        int id;
        logic [W-1:0] op;
        @(negedge HCLK);
        if (pend) begin
            rd[pend_idx] = rd[pend_idx] + 32'h0101_0101;
            pend = 1'b0;
        end
        if (rsp_valid !== 4'b0000) begin
            n_rsp++;
            if (q_id.size() == 0) sb_err++;
            else begin
                id = q_id.pop_front();
                op = q_op.pop_front();
                if (rsp_valid !== (4'b0001 << id) || rsp_data !== ~op) sb_err++;
            end
        end
        en        = e;
        man_valid = ret;
        man_data  = (q_op.size() != 0) ? ~q_op[0] : '0;
        req_valid = v;
        #1;
        gnt_seen = 1'b0;
        gnt_idx  = 0;
        if ($countones(req_ready) > 1) sb_err++;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gnt_seen = 1'b1;
                gnt_idx  = i;
            end
        end
        if (gnt_seen) begin
            q_id.push_back(gnt_idx);
            q_op.push_back(rd[gnt_idx]);
            pend     = 1'b1;
            pend_idx = gnt_idx;
        end
    endtask

    task automatic do_reset();
        HRESETn   = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        man_valid = 1'b0;
        core_auto = 1'b0;
        q_id.delete();
        q_op.delete();
        pend   = 1'b0;
        sb_err = 0;
        n_rsp  = 0;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            cycle('0, 1'b0, 1'b1);
            if (q_id.size() == 0 && idle === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        @(negedge HCLK);
        n_tot++; if (core_in_valid !== 1'b0) $display("FAIL rst_core_in_valid got %b want 0", core_in_valid); else n_pass++;
        n_tot++; if (core_in !== 32'h0) $display("FAIL rst_core_in got %h want 0", core_in); else n_pass++;
        n_tot++; if (rsp_valid !== 4'b0000) $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); else n_pass++;
        n_tot++; if (rsp_data !== 32'h0) $display("FAIL rst_rsp_data got %h want 0", rsp_data); else n_pass++;
        n_tot++; if (err_orphan !== 1'b0) $display("FAIL rst_err_orphan got %b want 0", err_orphan); else n_pass++;
        n_tot++; if (inflight !== 5'd0) $display("FAIL rst_inflight got %0d want 0", inflight); else n_pass++;
        n_tot++; if (idle !== 1'b1) $display("FAIL rst_idle got %b want 1", idle); else n_pass++;
        req_valid = 4'b1111;
        #1;
        n_tot++; if (req_ready !== 4'b0001) $display("FAIL rst_prio_all got %b want 0001", req_ready); else n_pass++;
        req_valid = 4'b1010;
        #1;
        n_tot++; if (req_ready !== 4'b0010) $display("FAIL rst_prio_1010 got %b want 0010", req_ready); else n_pass++;
        req_valid = 4'b0000;
        @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    task automatic test_single();
        @(negedge HCLK);
        rd[0]     = 32'h1234_5678;
        req_valid = 4'b0001;
        #1;
        n_tot++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready); else n_pass++;
        @(negedge HCLK);
        req_valid = 4'b0000;
        n_tot++; if (core_in_valid !== 1'b1) $display("FAIL single_in_valid got %b want 1", core_in_valid); else n_pass++;
        n_tot++; if (core_in !== 32'h1234_5678) $display("FAIL single_core_in got %h want 12345678", core_in); else n_pass++;
        n_tot++; if (inflight !== 5'd1) $display("FAIL single_inflight got %0d want 1", inflight); else n_pass++;
        n_tot++; if (idle !== 1'b0) $display("FAIL single_busy got %b want 0", idle); else n_pass++;
        @(negedge HCLK);
        n_tot++; if (core_in_valid !== 1'b0) $display("FAIL single_in_pulse got %b want 0", core_in_valid); else n_pass++;
        repeat (8) @(negedge HCLK);
        man_valid = 1'b1;
        man_data  = 32'h0000_CAFE;
        @(negedge HCLK);
        man_valid = 1'b0;
        n_tot++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid got %b want 0001", rsp_valid); else n_pass++;
        n_tot++; if (rsp_data !== 32'h0000_CAFE) $display("FAIL single_rsp_data got %h want 0000cafe", rsp_data); else n_pass++;
        n_tot++; if (inflight !== 5'd0) $display("FAIL single_retired got %0d want 0", inflight); else n_pass++;
        @(negedge HCLK);
        n_tot++; if (rsp_valid !== 4'b0000) $display("FAIL single_rsp_pulse got %b want 0000", rsp_valid); else n_pass++;
        n_tot++; if (idle !== 1'b1) $display("FAIL single_idle got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_fairness();
        int cnt [N];
        int n_g, prev, order_err;
        logic [15:0] first4;
        do_reset();
        core_auto = 1'b1;
        n_g = 0; prev = 3; order_err = 0; first4 = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 1000 && n_g < 400; c++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            if (gnt_seen) begin
                if (gnt_idx != (prev + 1) % N) order_err++;
                if (n_g < 4) first4[n_g*4 +: 4] = 4'(gnt_idx);
                cnt[gnt_idx]++;
                prev = gnt_idx;
                n_g++;
            end
        end
        drain();
        n_tot++; if (n_g != 400) $display("FAIL fair_grants got %0d want 400", n_g); else n_pass++;
        n_tot++; if (first4 !== 16'h3210) $display("FAIL fair_first4 got %h want 3210", first4); else n_pass++;
        n_tot++; if (order_err != 0) $display("FAIL fair_order got %0d breaks want 0", order_err); else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_tot++; if (cnt[i] != 100) $display("FAIL fair_share%0d got %0d want 100", i, cnt[i]); else n_pass++;
        end
        n_tot++; if (sb_err != 0) $display("FAIL fair_scoreboard got %0d errors want 0", sb_err); else n_pass++;
        n_tot++; if (n_rsp != 400) $display("FAIL fair_rsp_count got %0d want 400", n_rsp); else n_pass++;
        n_tot++; if (idle !== 1'b1) $display("FAIL fair_idle got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_routing();
        logic [3:0] pat [8];
        int n_g, mptr, rr_err, exp_idx;
        pat = '{4'b0101, 4'b1111, 4'b0010, 4'b1000, 4'b0000, 4'b1100, 4'b0011, 4'b1001};
        do_reset();
        core_auto = 1'b1;
        n_g = 0; mptr = 3; rr_err = 0;
        for (int c = 0; c < 200; c++) begin
            cycle(pat[c % 8], 1'b0, 1'b1);
            exp_idx = -1;
            for (int k = 1; k <= N; k++) begin
                if (exp_idx < 0 && pat[c % 8][(mptr + k) % N]) exp_idx = (mptr + k) % N;
            end
            if (gnt_seen) begin
                if (gnt_idx != exp_idx) rr_err++;
                mptr = gnt_idx;
                n_g++;
            end
        end
        drain();
        n_tot++; if (rr_err != 0) $display("FAIL route_rr got %0d wrong grants want 0", rr_err); else n_pass++;
        n_tot++; if (sb_err != 0) $display("FAIL route_scoreboard got %0d errors want 0", sb_err); else n_pass++;
        n_tot++; if (n_rsp != n_g || n_g == 0) $display("FAIL route_rsp_count got %0d want %0d", n_rsp, n_g); else n_pass++;
        n_tot++; if (inflight !== 5'd0) $display("FAIL route_drained got %0d want 0", inflight); else n_pass++;
    endtask

    task automatic test_full();
        int rr_err;
        do_reset();
        rr_err = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(4'b1111, 1'b0, 1'b1);
            if (!gnt_seen || gnt_idx != i % N) rr_err++;
        end
        cycle(4'b1111, 1'b0, 1'b1);
        n_tot++; if (rr_err != 0) $display("FAIL full_fill got %0d bad grants want 0", rr_err); else n_pass++;
        n_tot++; if (inflight !== 5'd16) $display("FAIL full_count got %0d want 16", inflight); else n_pass++;
        n_tot++; if (req_ready !== 4'b0000) $display("FAIL full_block got %b want 0000", req_ready); else n_pass++;
        cycle(4'b1111, 1'b1, 1'b1);
        n_tot++; if (req_ready !== 4'b0001) $display("FAIL full_retire_grant got %b want 0001", req_ready); else n_pass++;
        cycle(4'b1111, 1'b0, 1'b1);
        n_tot++; if (inflight !== 5'd16) $display("FAIL full_swap_count got %0d want 16", inflight); else n_pass++;
        n_tot++; if (req_ready !== 4'b0000) $display("FAIL full_reblock got %b want 0000", req_ready); else n_pass++;
        for (int i = 0; i < 16; i++) cycle(4'b0000, 1'b1, 1'b1);
        repeat (2) cycle(4'b0000, 1'b0, 1'b1);
        n_tot++; if (inflight !== 5'd0) $display("FAIL full_drained got %0d want 0", inflight); else n_pass++;
        n_tot++; if (sb_err != 0 || n_rsp != 17) $display("FAIL full_rsp got %0d rsp %0d errors want 17 rsp 0 errors", n_rsp, sb_err); else n_pass++;
    endtask

    task automatic test_en_drop();
        int ng_off;
        do_reset();
        ng_off = 0;
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            if (gnt_seen) ng_off++;
        end
        n_tot++; if (inflight !== 5'd5) $display("FAIL endrop_inflight got %0d want 5", inflight); else n_pass++;
        n_tot++; if (idle !== 1'b0) $display("FAIL endrop_busy got %b want 0", idle); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            if (gnt_seen) ng_off++;
        end
        repeat (2) cycle(4'b0000, 1'b0, 1'b0);
        n_tot++; if (ng_off != 0) $display("FAIL endrop_grants got %0d want 0", ng_off); else n_pass++;
        n_tot++; if (n_rsp != 5 || sb_err != 0) $display("FAIL endrop_rsp got %0d rsp %0d errors want 5 rsp 0 errors", n_rsp, sb_err); else n_pass++;
        n_tot++; if (idle !== 1'b1) $display("FAIL endrop_idle got %b want 1", idle); else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_orphan_reset();
        do_reset();
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        n_tot++; if (err_orphan !== 1'b1) $display("FAIL orphan_set got %b want 1", err_orphan); else n_pass++;
        n_tot++; if (rsp_valid !== 4'b0000) $display("FAIL orphan_no_rsp got %b want 0000", rsp_valid); else n_pass++;
        n_tot++; if (inflight !== 5'd0) $display("FAIL orphan_count got %0d want 0", inflight); else n_pass++;
        repeat (3) cycle(4'b0000, 1'b0, 1'b1);
        n_tot++; if (err_orphan !== 1'b1) $display("FAIL orphan_sticky got %b want 1", err_orphan); else n_pass++;
        core_auto = 1'b1;
        repeat (6) cycle(4'b1111, 1'b0, 1'b1);
        n_tot++; if (core_in_valid !== 1'b1) $display("FAIL burst_active got %b want 1", core_in_valid); else n_pass++;
        #2;
        HRESETn = 1'b0;
        #1;
        n_tot++; if (core_in_valid !== 1'b0) $display("FAIL arst_in_valid got %b want 0", core_in_valid); else n_pass++;
        n_tot++; if (core_in !== 32'h0) $display("FAIL arst_core_in got %h want 0", core_in); else n_pass++;
        n_tot++; if (err_orphan !== 1'b0) $display("FAIL arst_orphan got %b want 0", err_orphan); else n_pass++;
        n_tot++; if (inflight !== 5'd0) $display("FAIL arst_inflight got %0d want 0", inflight); else n_pass++;
        n_tot++; if (req_ready !== 4'b0001) $display("FAIL arst_ptr got %b want 0001", req_ready); else n_pass++;
        q_id.delete();
        q_op.delete();
        pend   = 1'b0;
        sb_err = 0;
        n_rsp  = 0;
        req_valid = '0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) cycle(4'b0000, 1'b0, 1'b1);
        n_tot++; if (err_orphan !== 1'b0 || n_rsp != 0) $display("FAIL arst_quiet got orphan %b rsp %0d want 0 0", err_orphan, n_rsp); else n_pass++;
        n_tot++; if (idle !== 1'b1) $display("FAIL arst_idle got %b want 1", idle); else n_pass++;
    endtask

    initial begin
        n_tot = 0; n_pass = 0; sb_err = 0; n_rsp = 0;
        HRESETn   = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        core_auto = 1'b0;
        man_valid = 1'b0;
        man_data  = '0;
        pend      = 1'b0;
        pend_idx  = 0;
        gnt_seen  = 1'b0;
        gnt_idx   = 0;
        for (int i = 0; i < N; i++) rd[i] = 32'h1000_0000 * (i + 1);
        test_reset();
        test_single();
        test_fairness();
        test_routing();
        test_full();
        test_en_drop();
        test_orphan_reset();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_cordic_req_arbiter
`default_nettype wire
